// File: rtl/delay_scheduler_if.sv
// Bus bundle for delay_scheduler: per-channel triggers and delays in,
// grant/busy/done/q/overrun status out.
// Optional abort input exists only when DELAY_SCHEDULER_ABORT_EN is defined.
interface delay_scheduler_if #(
  parameter int NumChannels = 4,
  parameter int DelayWidth  = 8
);
  logic [NumChannels-1:0]            trigger;
  logic [NumChannels*DelayWidth-1:0] delay;
  logic                              clear_overrun;
`ifdef DELAY_SCHEDULER_ABORT_EN
  logic                              abort;
`endif
  logic [NumChannels-1:0]            grant;
  logic                              busy;
  logic [NumChannels-1:0]            done;
  logic                              q;
  logic [NumChannels-1:0]            overrun;

`ifdef DELAY_SCHEDULER_ABORT_EN
  modport master (
    output trigger, delay, clear_overrun, abort,
    input  grant, busy, done, q, overrun
  );
  modport slave (
    input  trigger, delay, clear_overrun, abort,
    output grant, busy, done, q, overrun
  );
`else
  modport master (
    output trigger, delay, clear_overrun,
    input  grant, busy, done, q, overrun
  );
  modport slave (
    input  trigger, delay, clear_overrun,
    output grant, busy, done, q, overrun
  );
`endif
endinterface

// File: rtl/delay_scheduler.sv
// delay_scheduler: one shared countdown timer serving NumChannels trigger
// sources in round-robin order. Each trigger is held one-deep in a pending
// bit; the granted channel's delay is loaded and counted down, then a
// one-cycle done pulse is emitted on that channel.
// Optional feature macro: DELAY_SCHEDULER_ABORT_EN (adds the abort input).
module delay_scheduler #(
  parameter int NumChannels = 4,
  parameter int DelayWidth  = 8
) (
  input logic           clk,
  input logic           reset,
  delay_scheduler_if.slave bus
);

  localparam int IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state;
  logic [IdxW-1:0]        last;
  logic [DelayWidth-1:0]  timer;
  logic [NumChannels-1:0] pending;
  logic [NumChannels-1:0] grant;
  logic                   busy;
  logic [NumChannels-1:0] done;
  logic                   q;
  logic [NumChannels-1:0] overrun;

  logic                   pick_vld;
  logic [IdxW-1:0]        pick_idx;
  logic [NumChannels-1:0] pick_oh;
  logic [NumChannels-1:0] grant_now;
  logic [DelayWidth-1:0]  delay_sel;
  logic                   abort_now;

`ifdef DELAY_SCHEDULER_ABORT_EN
  assign abort_now = bus.abort;
`else
  assign abort_now = 1'b0;
`endif

  // Round-robin pick: first pending channel scanning upward from last+1.
  always_comb begin
    int              idx;
    logic [IdxW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= NumChannels; k++) begin
      idx = int'(last) + k;
      if (idx >= NumChannels) idx = idx - NumChannels;
      cand = IdxW'(idx);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    if (pick_vld) pick_oh[pick_idx] = 1'b1;
  end

  // A grant only happens from IDLE; arbitration uses registered pending only.
  assign grant_now = (state == IDLE && !abort_now) ? pick_oh : '0;

  // Delay field of the channel being picked, sampled only at the grant edge.
  always_comb begin
    delay_sel = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (int'(pick_idx) == i) delay_sel = bus.delay[i*DelayWidth +: DelayWidth];
    end
  end

  // One-deep request queue and sticky overrun flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else if (abort_now) begin
      // Abort flushes every queued request; same-cycle triggers are dropped
      // and therefore cannot count as lost-while-pending.
      pending <= '0;
      if (bus.clear_overrun) overrun <= '0;
    end else begin
      pending <= (pending & ~grant_now) | bus.trigger;
      if (bus.clear_overrun) begin
        overrun <= '0;
      end else begin
        overrun <= overrun | (bus.trigger & pending & ~grant_now);
      end
    end
  end

  // Scheduler FSM: grant and load timer in IDLE, count down and pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      done  <= '0;
      q     <= 1'b0;
      timer <= '0;
      last  <= IdxW'(NumChannels - 1);
    end else begin
      done <= '0;
      q    <= 1'b0;
      if (abort_now) begin
        // last already holds the aborted channel, so rotation continues
        // exactly as if that grant had completed.
        state <= IDLE;
        grant <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_vld) begin
              grant <= pick_oh;
              last  <= pick_idx;
              // Delays 0 and 1 both give the one-cycle minimum.
              timer <= (delay_sel == '0) ? '0 : delay_sel - DelayWidth'(1);
              busy  <= 1'b1;
              state <= COUNT;
            end
          end
          COUNT: begin
            if (timer == '0) begin
              done  <= grant;
              q     <= 1'b1;
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              timer <= timer - DelayWidth'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.grant   = grant;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.q       = q;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_delay_scheduler.sv
// Testbench for delay_scheduler: cycle table, hand-written corner sequences,
// and randomized traffic checked against a timeline reference model.
module tb_delay_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  delay_scheduler_if #(.NumChannels(NCH), .DelayWidth(DW)) bus ();

  delay_scheduler #(.NumChannels(NCH), .DelayWidth(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a request occupies the timer from its grant edge to
  // the edge max(D,1) later; the next grant needs an idle edge.
  bit [NCH-1:0] m_pend, m_over, m_done;
  int m_cur, m_end, m_last, m_cyc;

  task automatic model_reset();
    m_pend = '0; m_over = '0; m_done = '0;
    m_cur = -1; m_end = 0; m_last = NCH - 1; m_cyc = 0;
  endtask

  task automatic model_edge();
    int g, c, d;
    bit [NCH-1:0] tr;
    g = -1;
    tr = bus.trigger;
    m_done = '0;
    if (m_cur >= 0) begin
      if (m_cyc == m_end) begin
        m_done[m_cur] = 1'b1;
        m_cur = -1;
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (g < 0 && m_pend[c]) g = c;
      end
      if (g >= 0) begin
        d = int'(bus.delay[g*DW +: DW]);
        m_cur = g; m_last = g;
        m_end = m_cyc + ((d < 1) ? 1 : d);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus.clear_overrun) m_over[i] = 1'b0;
      else if (tr[i] && m_pend[i] && g != i) m_over[i] = 1'b1;
      m_pend[i] = (m_pend[i] && g != i) || tr[i];
    end
    m_cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    bus.trigger = '0;
    bus.clear_overrun = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    logic [NCH-1:0] eg;
    eg = (m_cur >= 0) ? NCH'(1 << m_cur) : '0;
    check({tag, "_grant"}, 32'(bus.grant), 32'(eg));
    check({tag, "_busy"}, 32'(bus.busy), 32'(m_cur >= 0));
    check({tag, "_done"}, 32'(bus.done), 32'(m_done));
    check({tag, "_q"}, 32'(bus.q), 32'(|m_done));
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_over));
  endtask

  // Single request on channel ch with delay d; done expected exp_lat edges after grant.
  task automatic single(input int ch, input int d, input int exp_lat, input string tag);
    int n, busy_bad;
    bit seen;
    logic [7:0] d8;
    reset_dut();
    d8 = d[7:0];
    bus.delay = '0;
    bus.delay[ch*DW +: DW] = d8;
    repeat (9) step();
    bus.trigger = NCH'(1 << ch);
    step();
    bus.trigger = '0;
    check({tag, "_no_grant_on_capture"}, 32'(bus.grant), 32'd0);
    step();
    check({tag, "_grant"}, 32'(bus.grant), 32'(1 << ch));
    check({tag, "_busy_at_grant"}, 32'(bus.busy), 32'd1);
    n = 0; seen = 0; busy_bad = 0;
    while (!seen && n < 300) begin
      step();
      n++;
      if (bus.done != '0) seen = 1;
      else if (!bus.busy) busy_bad++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_done"}, 32'(bus.done), 32'(1 << ch));
    check({tag, "_q"}, 32'(bus.q), 32'd1);
    check({tag, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_busy_gaps"}, 32'(busy_bad), 32'd0);
    step();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_q_one_cycle"}, 32'(bus.q), 32'd0);
  endtask

  typedef struct {
    logic [NCH-1:0] trig;
    logic           clr;
    logic [NCH-1:0] grant;
    logic           busy;
    logic [NCH-1:0] done;
    logic [NCH-1:0] over;
  } vec_t;

  vec_t vt[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, n_done;
    int order[$];
    logic [NCH-1:0] prev_g;

    vt[0]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    vt[1]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
    vt[2]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
    vt[3]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000};
    vt[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 4'b0000};
    vt[5]  = '{4'b0000, 1'b0, 4'b1000, 1'b1, 4'b0000, 4'b0000};
    vt[6]  = '{4'b0000, 1'b0, 4'b1000, 1'b1, 4'b0000, 4'b0000};
    vt[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000};
    vt[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    vt[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    vt[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000};
    vt[11] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0001};
    vt[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0000};
    vt[13] = '{4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000};
    vt[14] = '{4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000};
    vt[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000};

    bus.trigger = '0;
    bus.delay = '0;
    bus.clear_overrun = 1'b0;
`ifdef DELAY_SCHEDULER_ABORT_EN
    bus.abort = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(bus.grant), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_q", 32'(bus.q), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);

    // Cycle table: ch1/ch3 simultaneous (delays 3, 2), then ch0 overrun.
    reset_dut();
    bus.delay = {8'd2, 8'd1, 8'd3, 8'd2};
    for (int i = 0; i < 16; i++) begin
      bus.trigger = vt[i].trig;
      bus.clear_overrun = vt[i].clr;
      step();
      check($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vt[i].grant));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
      check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vt[i].done));
      check($sformatf("vec%0d_q", i), 32'(bus.q), 32'(|vt[i].done));
      check($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'(vt[i].over));
    end
    bus.trigger = '0;
    bus.clear_overrun = 1'b0;

    single(0, 5, 5, "single_d5");
    single(2, 0, 1, "min_d0");
    single(2, 1, 1, "min_d1");
    single(3, 255, 255, "max_d255");

    // Round robin with every channel hammering at delay 1.
    reset_dut();
    bus.delay = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.trigger = 4'hF;
    prev_g = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.grant != '0 && prev_g == '0) begin
        for (int c = 0; c < NCH; c++) if (bus.grant[c]) order.push_back(c);
      end
      prev_g = bus.grant;
    end
    ng = order.size();
    if (ng < 5) check("rr_grant_count", 32'(ng), 32'd5);
    else begin
      check("rr_order0", 32'(order[0]), 32'd0);
      check("rr_order1", 32'(order[1]), 32'd1);
      check("rr_order2", 32'(order[2]), 32'd2);
      check("rr_order3", 32'(order[3]), 32'd3);
      check("rr_order4", 32'(order[4]), 32'd0);
    end
    check("rr_overrun_all", 32'(bus.overrun), 32'hF);
    bus.clear_overrun = 1'b1;
    step();
    check("rr_clear_beats_set", 32'(bus.overrun), 32'd0);
    bus.clear_overrun = 1'b0;
    bus.trigger = '0;
    repeat (12) step();

    // Reset during a long count.
    reset_dut();
    bus.delay = {8'd1, 8'd1, 8'd200, 8'd1};
    bus.trigger = 4'b0010;
    step();
    bus.trigger = '0;
    step();
    check("rst_mid_grant", 32'(bus.grant), 32'b0010);
    repeat (50) step();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_grant0", 32'(bus.grant), 32'd0);
    check("rst_mid_busy0", 32'(bus.busy), 32'd0);
    check("rst_mid_done0", 32'(bus.done), 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
    n_done = 0;
    for (int i = 0; i < 220; i++) begin
      step();
      if (bus.done != '0 || bus.busy) n_done++;
    end
    check("rst_no_late_done", 32'(n_done), 32'd0);
    bus.trigger = 4'b0110;
    step();
    bus.trigger = '0;
    step();
    check("rst_priority_ch1", 32'(bus.grant), 32'b0010);
    repeat (5) step();

`ifdef DELAY_SCHEDULER_ABORT_EN
    // Abort three cycles into a delay-10 grant with channel 2 queued.
    reset_dut();
    bus.delay = {8'd1, 8'd4, 8'd1, 8'd10};
    bus.trigger = 4'b0001;
    step();
    bus.trigger = 4'b0100;
    step();
    bus.trigger = '0;
    check("abort_grant", 32'(bus.grant), 32'b0001);
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_grant0", 32'(bus.grant), 32'd0);
    check("abort_busy0", 32'(bus.busy), 32'd0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.done != '0 || bus.grant != '0) n_done++;
    end
    check("abort_nothing_after", 32'(n_done), 32'd0);
`endif

    // Randomized traffic against the reference model.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        bus.trigger[c] = ($urandom_range(0, 7) == 0);
        bus.delay[c*DW +: DW] = DW'($urandom_range(0, 5));
      end
      bus.clear_overrun = ($urandom_range(0, 31) == 0);
      step();
      check_model("rand");
    end
    bus.trigger = '0;
    bus.clear_overrun = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shares one delay timer among `NumChannels` trigger sources using round-robin arbitration. Each channel posts single-cycle triggers, and each trigger is queued one-deep. The scheduler loads the granted channel's delay, counts it down, and emits a one-cycle `done` pulse on that channel. It sits between the pulse-programmer trigger outputs and the shutter/DDS strobe logic, and replaces per-channel delay generators where channels never need overlapping delays.

## Interface
- `NumChannels`, default 4: number of requesting channels (2..16).
- `DelayWidth`, default 8: width of each channel's delay, in clock cycles.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `trigger` input `NumChannels`: per-channel single-cycle request pulses.
- `delay` input `NumChannels*DelayWidth`: channel i uses bits `[i*DelayWidth +: DelayWidth]`, sampled at the grant edge only.
- `clear_overrun` input 1: synchronous clear of all `overrun` bits.
- `abort` input 1: present only with `DELAY_SCHEDULER_ABORT_EN`, see Configuration.
- `grant` output `NumChannels`: one-hot channel currently being timed; zero when idle.
- `busy` output 1: high while in COUNT.
- `done` output `NumChannels`: one-hot, one-cycle pulse when the granted channel's delay expires.
- `q` output 1: OR of `done`.
- `overrun` output `NumChannels`: sticky flag, set when a trigger is lost.

## Operation
- Reset values: every output is 0; state is IDLE; `pending` is 0; `timer` is 0; `last` is `NumChannels-1`, so channel 0 has highest priority first.
- Pending register, updated every edge:
  - `pending <= (pending & ~grant_now) | trigger`.
  - `grant_now` is the one-hot channel chosen at this edge, or 0.
- Overrun: set `overrun[i]` when `trigger[i] & pending[i] & ~grant_now[i]`.
  - `clear_overrun` has priority over a set in the same cycle.
- A trigger on the currently granted channel is legal. It sets `pending` and is served after the current delay.
- States:
  - IDLE:
    - If `|pending`, select the first pending channel scanning upward from `last+1`, wrapping modulo `NumChannels`.
    - Set `grant` to that channel and `last` to its index.
    - Load `timer <= (delay_sel==0) ? 0 : delay_sel-1`, with width `DelayWidth`.
    - Go to COUNT. `busy` goes high.
  - COUNT:
    - If `timer==0`: set `done <= grant`, clear `grant` and `busy`, go to IDLE.
    - Otherwise decrement `timer`.
- Arbitration looks only at `pending` registered before the edge. A trigger never gets a grant on the edge where it is captured.
- Delays 0 and 1 behave identically: minimum one cycle.
- Maximum delay is `2^DelayWidth-1` cycles. There is no wrap.

## Timing
- Trigger on channel i captured at edge E. Grant at edge E+1 (call it T0), provided IDLE and channel i wins.
- `done[i]` and `q` are high for exactly the cycle following edge T0+max(D,1).
- After `done`, the next grant occurs at the earliest on the edge after the `done` edge.
- Back-to-back throughput is max(D,1)+1 cycles per served request.
- Worst-case wait for a queued request is `NumChannels-1` full services.
- `reset` mid-COUNT immediately forces IDLE and drops all outputs. The interrupted delay never produces `done`.

## Configuration
- `DELAY_SCHEDULER_ABORT_EN` defined:
  - Adds input `abort`.
  - When `abort` is high at an edge: go to IDLE, clear `grant`, `busy` and `pending`; no `done` is produced.
  - `trigger` bits in the same cycle are discarded.
  - `overrun` is unaffected.
  - `last` is updated as if the grant had completed.
- Not defined: no `abort` port. Every grant runs to `done`.

## Test plan
- Single request: channel 0, delay 5, trigger at edge 10. Expect grant at edge 11, `done[0]` and `q` high only after edge 16, `busy` high from edge 11 to edge 16.
- Minimum delay: delay 0 and delay 1 on channel 2. Both give `done[2]` one cycle after the grant edge.
- Simultaneous triggers: channels 1 and 3 (delays 3 and 2) at edge 10. Expect channel 1 granted at 11 with done at 14, channel 3 granted at 15 with done at 17.
- Round robin: all four channels triggered every cycle with delay 1. Expect grant order 0, 1, 2, 3, 0 and `overrun` set on all channels; `clear_overrun` clears them.
- Reset mid-COUNT: channel 1, delay 200, `reset` pulsed 50 cycles after grant. Expect all outputs 0 immediately, no `done`, and channel 0 highest priority afterwards.
- Abort (macro on): abort at 3 cycles into a delay-10 grant with channel 2 pending. Expect no `done`, `pending` 0, and IDLE on the next cycle.
